// File: rtl/product_accumulator_64b_pkg.sv
// ============================================================================
// Module  : acc_pkg
// Brief   : Shared state encoding and default widths for the product accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_GUARD  = 8;
  localparam int DEF_LENGTH = 16;
  localparam int DEF_CNT_W  = 8;

  localparam int ACC_W = DEF_PROD_W + DEF_GUARD;

endpackage

`default_nettype wire

// File: rtl/product_accumulator_64b_adder.sv
// ============================================================================
// Module  : acc_adder_72b
// Brief   : Zero-extends one product and adds it to the accumulator; exposes carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_adder_72b #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_term,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_term_ext;
  logic [ACC_W:0] w_total;

  assign w_term_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, i_term};
  assign w_total    = {1'b0, i_acc} + w_term_ext;
  assign o_sum      = w_total[ACC_W-1:0];
  assign o_carry    = w_total[ACC_W];

endmodule

`default_nettype wire

// File: rtl/product_accumulator_64b.sv
// ============================================================================
// Module  : product_accumulator_64b
// Brief   : Sums LENGTH (or fewer, on flush) unsigned products into a guarded
//           accumulator and presents each sum on a registered valid/ready port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module product_accumulator_64b
    import acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int GUARD  = DEF_GUARD,
    parameter int LENGTH = DEF_LENGTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PROD_W-1:0]         in_product,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [PROD_W+GUARD-1:0]   out_sum,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_overflow,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int               c_ACC_W    = PROD_W + GUARD;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(LENGTH - 1);

    logic               r_state;
    logic               w_state_next;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_acc_next;
    logic               w_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;

    logic               w_accept;
    logic               w_close;
    logic [c_ACC_W-1:0] w_sum_final;
    logic [CNT_W-1:0]   w_count_final;
    logic               w_ovf_final;

    logic [c_ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_overflow;
    logic               r_out_valid;

    acc_adder_72b #(
        .PROD_W (PROD_W),
        .ACC_W  (c_ACC_W)
    ) u_adder (
        .i_acc   (r_acc),
        .i_term  (in_product),
        .o_sum   (w_acc_next),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_close)   w_state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_next = ST_ACCUM;
        endcase
    end

    // in_ready is only ever high in ACCUM, so an accept implies ACCUM.
    always_comb begin
        w_accept      = in_valid && r_in_ready;
        w_close       = 1'b0;
        if (r_state == ST_ACCUM) begin
            w_close = (w_accept && (r_cnt == c_LAST_CNT)) ||
                      (flush && ((r_cnt != '0) || w_accept));
        end
        w_sum_final   = w_accept ? w_acc_next : r_acc;
        w_count_final = r_cnt + {{(CNT_W-1){1'b0}}, w_accept};
        w_ovf_final   = r_ovf | (w_accept & w_carry);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == ST_ACCUM);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_close) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_ovf <= r_ovf | w_carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_sum      <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
            r_out_valid    <= 1'b0;
        end else if (w_close) begin
            r_out_sum      <= w_sum_final;
            r_out_count    <= w_count_final;
            r_out_overflow <= w_ovf_final;
            r_out_valid    <= 1'b1;
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;
    assign out_valid    = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator_64b.sv
// ============================================================================
// Module  : tb_product_accumulator_64b
// Brief   : Self-checking bench with a queue-based reference model and directed cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_product_accumulator_64b;

  localparam int LENGTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_product = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic [71:0] out_sum;
  logic [7:0]  out_count;
  logic        out_overflow;
  logic        out_valid;

  logic [63:0] b_in_product = '1;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [64:0] b_out_sum;
  logic [7:0]  b_out_count;
  logic        b_out_overflow;
  logic        b_out_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_accumulator_64b dut (
    .clk(clk), .reset(reset), .in_product(in_product), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_sum(out_sum), .out_count(out_count),
    .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  product_accumulator_64b #(.PROD_W(64), .GUARD(1), .LENGTH(255), .CNT_W(8)) dut255 (
    .clk(clk), .reset(reset), .in_product(b_in_product), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(1'b0), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_overflow(b_out_overflow), .out_valid(b_out_valid), .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of taken terms and the beat last produced.
  logic [63:0]  m_terms[$];
  logic [127:0] m_tot;
  bit           m_hold = 1'b0;
  bit           m_rdy = 1'b0;
  logic [71:0]  m_sum = '0;
  logic [7:0]   m_cnt = '0;
  bit           m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_terms.delete();
      m_hold = 1'b0;
      m_rdy  = 1'b0;
      m_sum  = '0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_rdy  = 1'b1;
      end
    end else begin
      if (in_valid && m_rdy) m_terms.push_back(in_product);
      if (m_terms.size() == LENGTH || (flush && m_terms.size() > 0)) begin
        m_tot = '0;
        foreach (m_terms[i]) m_tot = m_tot + {64'd0, m_terms[i]};
        m_sum  = m_tot[71:0];
        m_ovf  = (m_tot[127:72] != '0);
        m_cnt  = 8'(m_terms.size());
        m_hold = 1'b1;
        m_rdy  = 1'b0;
        m_terms.delete();
      end else begin
        m_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {71'd0, in_ready}, {71'd0, m_rdy});
    chk("out_valid", {71'd0, out_valid}, {71'd0, m_hold});
    chk("out_sum", out_sum, m_sum);
    chk("out_count", {64'd0, out_count}, {64'd0, m_cnt});
    chk("out_overflow", {71'd0, out_overflow}, {71'd0, m_ovf});
  end

  task automatic send_term(input logic [63:0] v, input bit f, output int cyc);
    bit rdy;
    rdy = 1'b0;
    cyc = 0;
    in_product = v;
    in_valid   = 1'b1;
    flush      = f;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) break;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [71:0] s, input logic [7:0] c, input bit o);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got out_valid=0 expected out_valid=1", name);
    end else begin
      chk({name, "_sum"}, out_sum, s);
      chk({name, "_count"}, {64'd0, out_count}, {64'd0, c});
      chk({name, "_ovf"}, {71'd0, out_overflow}, {71'd0, o});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    logic [127:0] t255;
    bit seen;

    #1 reset = 1'b1;
    #2;
    chk("reset_out_valid", {71'd0, out_valid}, 72'd0);
    chk("reset_in_ready", {71'd0, in_ready}, 72'd0);
    chk("reset_out_sum", out_sum, 72'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("ready_after_release", {71'd0, in_ready}, 72'd1);

    // Sixteen ones.
    for (int i = 0; i < 16; i++) send_term(64'd1, 1'b0, cyc);
    chk("in_ready_low_after_16th", {71'd0, in_ready}, 72'd0);
    expect_beat("ones16", 72'd16, 8'd16, 1'b0);
    tick(1);
    chk("in_ready_back", {71'd0, in_ready}, 72'd1);

    // Sixteen all-ones products.
    for (int i = 0; i < 16; i++) send_term('1, 1'b0, cyc);
    expect_beat("max16", 72'h0F_FFFF_FFFF_FFFF_FFF0, 8'd16, 1'b0);
    tick(1);

    // Early flush together with the last term, then a lone flush.
    send_term(64'd5, 1'b0, cyc);
    send_term(64'd7, 1'b0, cyc);
    send_term(64'd9, 1'b1, cyc);
    expect_beat("flush3", 72'd21, 8'd3, 1'b0);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lone_flush_no_beat", {71'd0, out_valid}, 72'd0);
      tick(1);
    end

    // Backpressure: hold the beat for 5 cycles while in_valid pulses.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_term(64'(100 + i), 1'b0, cyc);
    expect_beat("hold", 72'd1720, 8'd16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid   = i[0];
      in_product = 64'hDEAD;
      tick(1);
      chk("hold_valid", {71'd0, out_valid}, 72'd1);
      chk("hold_in_ready", {71'd0, in_ready}, 72'd0);
      chk("hold_sum", out_sum, 72'd1720);
      chk("hold_count", {64'd0, out_count}, 72'd16);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    chk("post_hs_valid", {71'd0, out_valid}, 72'd0);
    chk("post_hs_ready", {71'd0, in_ready}, 72'd1);
    send_term(64'd42, 1'b1, cyc);
    chk("post_hs_accept_cycles", 72'(cyc), 72'd1);
    expect_beat("single", 72'd42, 8'd1, 1'b0);
    tick(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_product = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      flush      = ($urandom_range(0, 11) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(3);

    // Asynchronous reset in the middle of a sum.
    for (int i = 0; i < 7; i++) send_term(64'd1, 1'b0, cyc);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_valid", {71'd0, out_valid}, 72'd0);
    chk("midreset_ready", {71'd0, in_ready}, 72'd0);
    chk("midreset_count", {64'd0, out_count}, 72'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) send_term(64'd1, 1'b0, cyc);
    expect_beat("after_reset", 72'd16, 8'd16, 1'b0);
    tick(2);

    // LENGTH=255, GUARD=1 instance with all-ones terms.
    t255 = 128'd255 * 128'hFFFF_FFFF_FFFF_FFFF;
    chk("model255_literal", {7'd0, t255[64:0]}, {7'd0, 65'h0_FFFF_FFFF_FFFF_FF01});
    b_in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (b_out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    b_in_valid = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL len255_timeout: got out_valid=0 expected out_valid=1");
    end else begin
      chk("len255_sum", {7'd0, b_out_sum}, {7'd0, t255[64:0]});
      chk("len255_count", {64'd0, b_out_count}, 72'd255);
      chk("len255_ovf", {71'd0, b_out_overflow}, 72'd1);
    end
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
